// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 FIFO-interface blocks (TX and RX):
// FSM state codes, default bus timing and a ceil-divide helper used to
// turn nanosecond timing into clock counts.
package ft245_pkg;

    // Default FT245 bus timing, in ns.
    localparam int DEF_CLOCK_PERIOD_NS = 10;
    localparam int DEF_WR_PULSE_NS     = 50;
    localparam int DEF_DATA_SETUP_NS   = 20;
    localparam int DEF_TXE_RECOVERY_NS = 80;

    // FSM state codes.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_TXE = 3'd1;
    localparam logic [2:0] ST_SETUP    = 3'd2;
    localparam logic [2:0] ST_STROBE   = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_RECOVER  = 3'd5;

    // ceil(num/den), never less than one cycle.
    function automatic int ceil_div(input int num, input int den);
        int q;
        q = (num + den - 1) / den;
        return (q < 1) ? 1 : q;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ft245_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (TXE#, RXF#).
// The reset value is chosen so the synchronized signal reads "inactive".
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronisation into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ft245_tx.sv
// FT245 transmit side: takes one byte at a time from a rdy/ack source and
// writes it to the FT245 FIFO with a timed setup / WR strobe / hold / recovery
// sequence. All bus-side outputs are registered.
//
// Source handshake: the source holds tx_data_si valid while tx_rdy_si=1; the
// block samples it only in IDLE, and tx_ack_si pulses for one cycle right after
// the byte has been captured. The source may present its next byte in that
// ack cycle; rdy is not looked at again until the block is back in IDLE.
module ft245_tx
    import ft245_pkg::*;
#(
    parameter int CLOCK_PERIOD_NS = DEF_CLOCK_PERIOD_NS,
    parameter int WR_PULSE_NS     = DEF_WR_PULSE_NS,
    parameter int DATA_SETUP_NS   = DEF_DATA_SETUP_NS,
    parameter int TXE_RECOVERY_NS = DEF_TXE_RECOVERY_NS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_si,
    input  logic       tx_rdy_si,
    output logic       tx_ack_si,
    input  logic       txe_245,
    output logic       wr_245,
    output logic [7:0] tx_data_245,
    output logic       tx_oe_245,
    output logic [2:0] fsm_state
);

    localparam int N_SU  = ceil_div(DATA_SETUP_NS, CLOCK_PERIOD_NS);
    localparam int N_WR  = ceil_div(WR_PULSE_NS, CLOCK_PERIOD_NS);
    localparam int N_RC  = ceil_div(TXE_RECOVERY_NS, CLOCK_PERIOD_NS);
    localparam int N_MAX = max3(N_SU, N_WR, N_RC);
    localparam int CNT_W = $clog2(N_MAX + 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       hold;
    logic             txe_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_txe_sync (
        .clk (clk),
        .rst (rst),
        .d   (txe_245),
        .q   (txe_s)
    );

    assign fsm_state = state;

    // Transfer sequencer. The first WAIT_TXE cycle is the ack cycle; TXE# is
    // only acted on from the following cycle, which leaves the synchronizer
    // its two cycles even when TXE# is already low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hold        <= 8'h00;
            tx_data_245 <= 8'h00;
            wr_245      <= 1'b0;
            tx_oe_245   <= 1'b0;
            tx_ack_si   <= 1'b0;
        end else begin
            tx_ack_si <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_rdy_si) begin
                        hold      <= tx_data_si;
                        tx_ack_si <= 1'b1;
                        state     <= ST_WAIT_TXE;
                    end
                end
                ST_WAIT_TXE: begin
                    if (!txe_s && !tx_ack_si) begin
                        tx_data_245 <= hold;
                        tx_oe_245   <= 1'b1;
                        cnt         <= CNT_W'(N_SU);
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CNT_W'(1)) begin
                        wr_245 <= 1'b1;
                        cnt    <= CNT_W'(N_WR);
                        state  <= ST_STROBE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt == CNT_W'(1)) begin
                        wr_245 <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    tx_oe_245 <= 1'b0;
                    cnt       <= CNT_W'(N_RC);
                    state     <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    wr_245    <= 1'b0;
                    tx_oe_245 <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_tx.sv
// Bench for ft245_tx: a timestamp-level transfer model predicts ack/wr/oe/data
// every cycle; directed scenarios pin the model with literal timings, and a
// second instance at a 33 ns clock checks the rescaled strobe widths.
module tb_ft245_tx;

    // Hand-derived counts at 10 ns: ceil(20/10), ceil(50/10), ceil(80/10).
    localparam int N_SU = 2;
    localparam int N_WR = 5;
    localparam int N_RC = 8;
    localparam int XFER = N_SU + N_WR + 1 + N_RC;   // edges from decide to free

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b0;
    logic       txe = 1'b1;
    logic [7:0] din = 8'h00;

    logic       ack, wr, oe;
    logic [7:0] dout;
    logic [2:0] st;
    logic       ack33, wr33, oe33;
    logic [7:0] dout33;
    logic [2:0] st33;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    ft245_tx dut (
        .clk (clk), .rst (rst), .tx_data_si (din), .tx_rdy_si (rdy),
        .tx_ack_si (ack), .txe_245 (txe), .wr_245 (wr),
        .tx_data_245 (dout), .tx_oe_245 (oe), .fsm_state (st)
    );

    ft245_tx #(.CLOCK_PERIOD_NS(33)) dut33 (
        .clk (clk), .rst (rst), .tx_data_si (din), .tx_rdy_si (rdy),
        .tx_ack_si (ack33), .txe_245 (txe), .wr_245 (wr33),
        .tx_data_245 (dout33), .tx_oe_245 (oe33), .fsm_state (st33)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- clock/reset bookkeeping ----------------
    logic last_rst = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rst <= rst;
    end

    // ---------------- behavioural model ----------------
    // A transfer is: accept edge, then a decide edge (first edge at least two
    // after accept where the 2-flop-delayed TXE# is low), then fixed offsets.
    bit         m_valid = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_edge  = 0;
    int         m_acc, m_dec, m_r;
    logic [7:0] m_hold;
    logic [7:0] m_data  = 8'h00;
    bit         m_s1 = 1'b1, m_s2 = 1'b1, m_txe_s;
    bit         e_ack = 1'b0, e_wr = 1'b0, e_oe = 1'b0;

    always @(posedge clk) begin
        m_edge++;
        m_txe_s = m_s2;
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_data  = 8'h00;
            m_s1    = 1'b1;
            m_s2    = 1'b1;
            e_ack   = 1'b0;
            e_wr    = 1'b0;
            e_oe    = 1'b0;
        end else begin
            m_s2  = m_s1;
            m_s1  = txe;
            e_ack = 1'b0;
            if (!m_busy) begin
                if (rdy) begin
                    m_busy = 1'b1;
                    m_acc  = m_edge;
                    m_dec  = -1;
                    m_hold = din;
                    e_ack  = 1'b1;
                end
            end else if (m_dec < 0) begin
                if (m_edge >= m_acc + 2 && !m_txe_s) begin
                    m_dec  = m_edge;
                    m_data = m_hold;
                end
            end else if (m_edge - m_dec == XFER) begin
                m_busy = 1'b0;
            end
            e_oe = 1'b0;
            e_wr = 1'b0;
            if (m_busy && m_dec >= 0) begin
                m_r  = m_edge - m_dec;
                e_oe = (m_r < N_SU + N_WR + 1);
                e_wr = (m_r >= N_SU) && (m_r < N_SU + N_WR);
            end
        end
    end

    // ---------------- compare + monitors ----------------
    int         rise_q[$];
    logic [7:0] rise_data_q[$];
    int         len_q[$];
    logic [7:0] oe_data_q[$];
    logic [7:0] exp_q[$];
    int  ack_tot = 0;
    int  run = 0, run33 = 0, orun33 = 0;
    bit  wr_prev = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ack", ack, e_ack);
            chk("wr", wr, e_wr);
            chk("oe", oe, e_oe);
            chk("data", dout, m_data);
            chk("wr33_implies_oe33", wr33 & ~oe33, 0);

            if (ack) ack_tot++;
            if (oe) oe_data_q.push_back(dout);
            if (wr && !wr_prev) begin
                rise_q.push_back(cyc);
                rise_data_q.push_back(dout);
            end
            wr_prev = wr;

            if (last_rst) begin
                run = 0; run33 = 0; orun33 = 0;
            end
            if (wr) run++;
            else if (run > 0) begin
                len_q.push_back(run);
                run = 0;
            end
            if (wr33) run33++;
            else if (run33 > 0) begin
                chk("wr33_len", run33, 2);
                chk("wr33_ns_ge_50", (run33 * 33 >= 50), 1);
                run33 = 0;
            end
            if (oe33) orun33++;
            else if (orun33 > 0) begin
                chk("oe33_len", orun33, 4);
                orun33 = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        rdy = 1'b1;
        din = b;
        step();
        rdy = 1'b0;
        din = 8'($urandom);
    endtask

    task automatic wait_rise(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            step();
            if (wr) break;
        end
        if (k == budget) chk({name, "_wr_timeout"}, 0, 1);
    endtask

    // ---------------- stimulus ----------------
    int ack0, nr0, oe0, nlen0, bad, c, r_cyc, sent, k;

    initial begin
        steps(3);
        chk("reset_wr", wr, 0);
        chk("reset_oe", oe, 0);
        chk("reset_ack", ack, 0);
        chk("reset_data", dout, 8'h00);
        rst = 1'b0;

        // Single byte, TXE# already low.
        txe = 1'b0;
        steps(3);
        ack0 = ack_tot; nr0 = rise_q.size(); oe0 = oe_data_q.size(); nlen0 = len_q.size();
        send(8'hA5);
        c = cyc;
        steps(30);
        chk("s1_acks", ack_tot - ack0, 1);
        chk("s1_strobes", rise_q.size() - nr0, 1);
        chk("s1_oe_cycles", oe_data_q.size() - oe0, 8);
        chk("s1_wr_len", (len_q.size() > nlen0) ? len_q[nlen0] : 0, 5);
        chk("s1_wr_rise_cycle", (rise_q.size() > nr0) ? rise_q[nr0] - c : -1, 4);
        bad = 0;
        for (int i = oe0; i < oe_data_q.size(); i++) if (oe_data_q[i] != 8'hA5) bad++;
        chk("s1_data_stable", bad, 0);

        // TXE# high: byte acked but no write until TXE# drops.
        txe = 1'b1;
        steps(3);
        ack0 = ack_tot; nr0 = rise_q.size();
        send(8'h3C);
        steps(30);
        chk("s2_acks", ack_tot - ack0, 1);
        chk("s2_no_strobe", rise_q.size() - nr0, 0);
        txe = 1'b0;
        r_cyc = cyc;
        wait_rise("s2", 20);
        chk("s2_release_latency", cyc - (r_cyc + 1), 4);
        steps(25);
        chk("s2_data", (rise_data_q.size() > nr0) ? rise_data_q[nr0] : 8'hxx, 8'h3C);

        // Streaming four bytes with ack loopback.
        nr0 = rise_q.size();
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        rdy = 1'b1; din = 8'h01; sent = 0;
        for (k = 0; k < 200 && sent < 4; k++) begin
            step();
            if (ack) begin
                sent++;
                if (sent == 4) rdy = 1'b0;
                else din = 8'(sent + 1);
            end
        end
        rdy = 1'b0;
        chk("s3_all_acked", sent, 4);
        steps(30);
        chk("s3_strobes", rise_q.size() - nr0, 4);
        for (int i = 0; i < 3; i++)
            if (rise_q.size() > nr0 + i + 1)
                chk("s3_rise_gap", rise_q[nr0 + i + 1] - rise_q[nr0 + i], 19);
        for (int i = 0; i < 4; i++) begin
            if (rise_data_q.size() > nr0 + i && exp_q.size() > 0)
                chk("s3_order", rise_data_q[nr0 + i], exp_q.pop_front());
        end

        // Reset during the third strobe cycle.
        send(8'h55);
        wait_rise("s4", 20);
        steps(2);
        rst = 1'b1;
        step();
        chk("s4_rst_wr", wr, 0);
        chk("s4_rst_oe", oe, 0);
        rst = 1'b0;
        ack0 = ack_tot; nr0 = rise_q.size();
        steps(25);
        chk("s4_no_reack", ack_tot - ack0, 0);
        chk("s4_no_restrobe", rise_q.size() - nr0, 0);
        nlen0 = len_q.size();
        send(8'h77);
        wait_rise("s4b", 20);
        steps(25);
        chk("s4_next_data", (rise_data_q.size() > nr0) ? rise_data_q[nr0] : 8'hxx, 8'h77);
        chk("s4_next_len", (len_q.size() > nlen0) ? len_q[nlen0] : 0, 5);

        // TXE# toggling during the strobe.
        nr0 = rise_q.size(); nlen0 = len_q.size();
        send(8'h9C);
        wait_rise("s5", 20);
        for (int i = 0; i < 6; i++) begin
            txe = ~txe;
            step();
        end
        txe = 1'b0;
        steps(25);
        chk("s5_one_write", rise_q.size() - nr0, 1);
        chk("s5_len", (len_q.size() > nlen0) ? len_q[nlen0] : 0, 5);

        // Random traffic, TXE# bursts and occasional resets.
        for (int i = 0; i < 800; i++) begin
            rdy = ($urandom_range(0, 3) == 0);
            din = 8'($urandom);
            if ($urandom_range(0, 5) == 0) txe = ~txe;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; rdy = 1'b0; txe = 1'b0;
        steps(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
